// File: rtl/rgmii_speed_ctrl.sv
// RGMII link-speed controller.
// Decodes in-band link status from the RX nibble during inter-frame gaps,
// debounces it, and sequences PHY speed changes: drain TX, switch speed,
// then hold the MAC in reset. A software force override selects the speed directly.
module rgmii_speed_ctrl #(
   parameter int unsigned STABLE_CYCLES = 1024,
   parameter int unsigned DRAIN_CYCLES  = 64,
   parameter int unsigned RESET_CYCLES  = 16,
   parameter logic [1:0]  DEFAULT_SPEED = 2'b10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_dv,
   input  logic       rx_er,
   input  logic [3:0] rxd,
   input  logic       tx_en,
   input  logic       cfg_force_en,
   input  logic [1:0] cfg_force_speed,
   output logic [1:0] speed,
   output logic       link_up,
   output logic       full_duplex,
   output logic       mac_tx_hold,
   output logic       mac_rst,
   output logic [7:0] change_count
);

   localparam int unsigned CNT_MAX = (DRAIN_CYCLES > RESET_CYCLES) ? DRAIN_CYCLES : RESET_CYCLES;
   localparam int unsigned CW      = $clog2(CNT_MAX + 1);
   localparam int unsigned SW      = $clog2(STABLE_CYCLES + 1);

   localparam logic [SW-1:0] STABLE_N   = SW'(STABLE_CYCLES);
   localparam logic [CW-1:0] DRAIN_N    = CW'(DRAIN_CYCLES);
   localparam logic [CW-1:0] RESET_LAST = CW'(RESET_CYCLES - 1);

   typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_SWITCH, ST_RESET} state_t;

   // {rx_dv, rx_er, rxd}; the reset value marks the sample as not valid
   logic [5:0]    sync1_q, sync2_q;
   logic [3:0]    cand_q, cand_d;
   logic [SW-1:0] stab_q, stab_d;
   logic          link_q, dup_q;
   logic [1:0]    cspd_q;
   logic          samp_valid;
   logic [1:0]    target;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    speed_q, speed_d;
   logic [7:0]    chg_q, chg_d;
   logic          hold_q, hold_d;
   logic          mrst_q, mrst_d;

   // Two-flop synchronizer for the asynchronous RX signals
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= 6'b10_0000;
         sync2_q <= 6'b10_0000;
      end else begin
         sync1_q <= {rx_dv, rx_er, rxd};
         sync2_q <= sync1_q;
      end
   end

   // Samples with a reserved speed code of 11 carry no usable status
   assign samp_valid = !sync2_q[5] && !sync2_q[4] && (sync2_q[2:1] != 2'b11);

   // Stability counter: track a candidate status word and how long it has held
   always_comb begin
      cand_d = cand_q;
      stab_d = stab_q;
      if (samp_valid) begin
         if (sync2_q[3:0] == cand_q) begin
            if (stab_q != STABLE_N) stab_d = stab_q + SW'(1);
         end else begin
            cand_d = sync2_q[3:0];
            stab_d = SW'(1);
         end
      end
   end

   // Candidate/count registers and commit of the debounced status
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cand_q <= 4'd0;
         stab_q <= '0;
         link_q <= 1'b0;
         dup_q  <= 1'b0;
         cspd_q <= 2'b00;
      end else begin
         cand_q <= cand_d;
         stab_q <= stab_d;
         if (stab_q == STABLE_N) begin
            link_q <= cand_q[0];
            cspd_q <= cand_q[2:1];
            dup_q  <= cand_q[3];
         end
      end
   end

   // Target speed: force override, else committed in-band speed while link is up
   always_comb begin
      target = speed_q;
      if (cfg_force_en)
         target = (cfg_force_speed == 2'b11) ? 2'b10 : cfg_force_speed;
      else if (link_q)
         target = cspd_q;
   end

   // Speed-change sequencer: next state, counter and registered outputs
   always_comb begin
      logic [CW-1:0] drain_nxt;
      state_d   = state_q;
      cnt_d     = cnt_q;
      speed_d   = speed_q;
      chg_d     = chg_q;
      drain_nxt = tx_en ? '0 : cnt_q + CW'(1);
      case (state_q)
         ST_RUN: begin
            if (target != speed_q) begin
               state_d = ST_DRAIN;
               cnt_d   = '0;
            end
         end
         ST_DRAIN: begin
            if (target == speed_q) begin
               state_d = ST_RUN;
               cnt_d   = '0;
            end else if (drain_nxt == DRAIN_N) begin
               // The switch cycle counts as the first cycle of the MAC reset
               state_d = ST_SWITCH;
               cnt_d   = CW'(1);
               speed_d = target;
               if (chg_q != 8'hFF) chg_d = chg_q + 8'd1;
            end else begin
               cnt_d = drain_nxt;
            end
         end
         ST_SWITCH: begin
            if (RESET_CYCLES <= 1) begin
               state_d = ST_RUN;
               cnt_d   = '0;
            end else begin
               state_d = ST_RESET;
            end
         end
         ST_RESET: begin
            if (cnt_q >= RESET_LAST) begin
               state_d = ST_RUN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            state_d = ST_RESET;
            cnt_d   = '0;
         end
      endcase
      hold_d = (state_d != ST_RUN);
      mrst_d = (state_d == ST_SWITCH) || (state_d == ST_RESET);
   end

   // Sequencer state and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_RESET;
         cnt_q   <= '0;
         speed_q <= DEFAULT_SPEED;
         chg_q   <= 8'd0;
         hold_q  <= 1'b1;
         mrst_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         speed_q <= speed_d;
         chg_q   <= chg_d;
         hold_q  <= hold_d;
         mrst_q  <= mrst_d;
      end
   end

   assign speed        = speed_q;
   assign link_up      = link_q;
   assign full_duplex  = dup_q;
   assign mac_tx_hold  = hold_q;
   assign mac_rst      = mrst_q;
   assign change_count = chg_q;

endmodule

// File: tb/tb_rgmii_speed_ctrl.sv
// Testbench for rgmii_speed_ctrl with small timing parameters.
module tb_rgmii_speed_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx_dv = 1'b0;
   logic       rx_er = 1'b0;
   logic [3:0] rxd = 4'd0;
   logic       tx_en = 1'b0;
   logic       cfg_force_en = 1'b0;
   logic [1:0] cfg_force_speed = 2'b00;
   logic [1:0] speed;
   logic       link_up, full_duplex, mac_tx_hold, mac_rst;
   logic [7:0] change_count;

   rgmii_speed_ctrl #(
      .STABLE_CYCLES(8),
      .DRAIN_CYCLES(4),
      .RESET_CYCLES(3),
      .DEFAULT_SPEED(2'b10)
   ) dut (
      .clk(clk),
      .rst(rst),
      .rx_dv(rx_dv),
      .rx_er(rx_er),
      .rxd(rxd),
      .tx_en(tx_en),
      .cfg_force_en(cfg_force_en),
      .cfg_force_speed(cfg_force_speed),
      .speed(speed),
      .link_up(link_up),
      .full_duplex(full_duplex),
      .mac_tx_hold(mac_tx_hold),
      .mac_rst(mac_rst),
      .change_count(change_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       fe;
      logic [1:0] fs;
      logic [3:0] rxd;
      logic [1:0] exp_speed;
      logic       exp_link;
      logic       exp_dup;
   } vec_t;

   typedef struct {
      logic [1:0] spd;
      logic [7:0] cnt;
   } sw_t;

   vec_t       vtab[9];
   sw_t        sw_q[$];
   int         n_vec = 0;
   int         n_bad = 0;
   logic [1:0] cur_spd = 2'b10;
   logic [7:0] exp_cnt = 8'd0;
   logic [7:0] prev_cnt = 8'd0;

   task automatic chk(input string nm, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   // Record that a speed switch to s is now expected
   task automatic expect_switch(input logic [1:0] s);
      sw_t e;
      if (exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
      e.spd = s;
      e.cnt = exp_cnt;
      sw_q.push_back(e);
      cur_spd = s;
   endtask

   // Switch monitor: each change_count step is matched against the queue
   always begin
      sw_t e;
      @(posedge clk);
      #1;
      if (rst) begin
         prev_cnt = change_count;
      end else if (change_count != prev_cnt) begin
         if (sw_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL unexpected_switch: speed=%0d count=%0d, expected no switch", speed, change_count);
         end else begin
            e = sw_q.pop_front();
            chk("sw_speed", int'(speed), int'(e.spd));
            chk("sw_count", int'(change_count), int'(e.cnt));
            chk("sw_mac_rst", int'(mac_rst), 1);
         end
         prev_cnt = change_count;
      end
   end

   task automatic check_reset_vals(input string tag);
      chk({tag, "_speed"}, int'(speed), 2);
      chk({tag, "_link"}, int'(link_up), 0);
      chk({tag, "_dup"}, int'(full_duplex), 0);
      chk({tag, "_hold"}, int'(mac_tx_hold), 1);
      chk({tag, "_mac_rst"}, int'(mac_rst), 1);
      chk({tag, "_count"}, int'(change_count), 0);
   endtask

   // Called right after rst falls: mac_rst must fall on the 3rd edge, with hold
   task automatic measure_release(input string nm);
      int n = 0;
      int hold_err = 0;
      for (int i = 1; i <= 10; i++) begin
         @(posedge clk);
         #1;
         if (mac_rst && !mac_tx_hold) hold_err = 1;
         if (!mac_rst) begin
            n = i;
            break;
         end
      end
      chk(nm, n, 3);
      chk({nm, "_hold_fall"}, int'(mac_tx_hold), 0);
      chk({nm, "_hold_err"}, hold_err, 0);
      @(negedge clk);
   endtask

   task automatic sample(input logic dv, input logic [3:0] d);
      rx_dv = dv;
      rxd   = d;
      @(negedge clk);
   endtask

   task automatic run_vec(input int idx);
      vec_t v;
      logic sw;
      int   drain = 0;
      int   rlen = 0;
      int   saw = 0;
      v = vtab[idx];
      cfg_force_en    = v.fe;
      cfg_force_speed = v.fs;
      rxd   = v.rxd;
      rx_dv = 1'b0;
      rx_er = 1'b0;
      tx_en = 1'b0;
      sw = (v.exp_speed != cur_spd);
      if (sw) expect_switch(v.exp_speed);
      repeat (60) begin
         @(posedge clk);
         #1;
         if (mac_tx_hold) saw = 1;
         if (mac_tx_hold && !mac_rst) drain++;
         if (mac_rst) rlen++;
      end
      @(negedge clk);
      chk($sformatf("v%0d_speed", idx), int'(speed), int'(v.exp_speed));
      chk($sformatf("v%0d_link", idx), int'(link_up), int'(v.exp_link));
      chk($sformatf("v%0d_dup", idx), int'(full_duplex), int'(v.exp_dup));
      chk($sformatf("v%0d_count", idx), int'(change_count), int'(exp_cnt));
      chk($sformatf("v%0d_hold", idx), int'(mac_tx_hold), 0);
      if (sw) begin
         chk($sformatf("v%0d_drain_len", idx), drain, 4);
         chk($sformatf("v%0d_rst_len", idx), rlen, 3);
      end else begin
         chk($sformatf("v%0d_no_activity", idx), saw, 0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int any_rst;
      //           fe    fs     rxd      speed  link  dup
      vtab[0] = '{1'b0, 2'b00, 4'b1011, 2'b01, 1'b1, 1'b1};  // in-band 100M full
      vtab[1] = '{1'b0, 2'b00, 4'b0101, 2'b10, 1'b1, 1'b0};  // in-band 1G half
      vtab[2] = '{1'b0, 2'b00, 4'b0001, 2'b00, 1'b1, 1'b0};  // in-band 10M
      vtab[3] = '{1'b0, 2'b00, 4'b1110, 2'b00, 1'b1, 1'b0};  // spd=11 ignored
      vtab[4] = '{1'b0, 2'b00, 4'b1100, 2'b00, 1'b0, 1'b1};  // link down: hold speed
      vtab[5] = '{1'b1, 2'b11, 4'b1100, 2'b10, 1'b0, 1'b1};  // force 11 -> 1G
      vtab[6] = '{1'b1, 2'b00, 4'b1100, 2'b00, 1'b0, 1'b1};  // force 10M
      vtab[7] = '{1'b1, 2'b01, 4'b0011, 2'b01, 1'b1, 1'b0};  // force 100M
      vtab[8] = '{1'b0, 2'b00, 4'b0011, 2'b01, 1'b1, 1'b0};  // in-band agrees

      // Reset state and post-reset MAC reset pulse, idle RX
      repeat (3) @(negedge clk);
      check_reset_vals("rst");
      rst = 1'b0;
      measure_release("t1_pulse");
      repeat (20) @(negedge clk);
      chk("t1_speed", int'(speed), 2);
      chk("t1_link", int'(link_up), 0);
      chk("t1_hold", int'(mac_tx_hold), 0);
      chk("t1_count", int'(change_count), 0);

      for (int i = 0; i < 9; i++) run_vec(i);

      // Stability count pauses on rx_dv bursts, restarts on a differing sample
      repeat (3) sample(1'b0, 4'b1011);
      repeat (5) sample(1'b1, 4'b1011);
      repeat (4) sample(1'b0, 4'b1011);
      repeat (5) sample(1'b1, 4'b1011);
      chk("t3_dup_after7", int'(full_duplex), 0);
      sample(1'b0, 4'b1011);
      repeat (5) sample(1'b1, 4'b1011);
      chk("t3_dup_after8", int'(full_duplex), 1);
      chk("t3_link", int'(link_up), 1);
      repeat (5) sample(1'b0, 4'b0011);
      sample(1'b0, 4'b1101);
      repeat (5) sample(1'b0, 4'b0011);
      repeat (5) sample(1'b1, 4'b0011);
      chk("t3_restart_dup", int'(full_duplex), 1);
      repeat (3) sample(1'b0, 4'b0011);
      repeat (5) sample(1'b1, 4'b0011);
      chk("t3_recommit_dup", int'(full_duplex), 0);
      chk("t3_speed", int'(speed), 1);
      chk("t3_hold", int'(mac_tx_hold), 0);

      // Drain waits for tx_en to stay low for 4 cycles
      cfg_force_en    = 1'b1;
      cfg_force_speed = 2'b10;
      tx_en           = 1'b1;
      repeat (20) @(negedge clk);
      chk("t4_hold", int'(mac_tx_hold), 1);
      chk("t4_speed_held", int'(speed), 1);
      chk("t4_no_rst", int'(mac_rst), 0);
      expect_switch(2'b10);
      tx_en = 1'b0;
      n = 0;
      for (int i = 1; i <= 10; i++) begin
         @(posedge clk);
         #1;
         if (speed == 2'b10) begin
            n = i;
            break;
         end
      end
      chk("t4_latency", n, 4);
      repeat (8) @(negedge clk);
      chk("t4_hold_done", int'(mac_tx_hold), 0);

      // Request reverted inside DRAIN, then force 11 maps to 1G
      cfg_force_speed = 2'b00;
      tx_en = 1'b1;
      repeat (3) @(negedge clk);
      chk("t5_in_drain", int'(mac_tx_hold), 1);
      cfg_force_speed = 2'b10;
      any_rst = 0;
      repeat (6) begin
         @(negedge clk);
         if (mac_rst) any_rst = 1;
      end
      chk("t5_no_rst", any_rst, 0);
      chk("t5_hold", int'(mac_tx_hold), 0);
      chk("t5_speed", int'(speed), 2);
      chk("t5_count", int'(change_count), int'(exp_cnt));
      tx_en = 1'b0;
      cfg_force_speed = 2'b01;
      expect_switch(2'b01);
      repeat (15) @(negedge clk);
      chk("t5_speed01", int'(speed), 1);
      cfg_force_speed = 2'b11;
      expect_switch(2'b10);
      repeat (15) @(negedge clk);
      chk("t5_speed11", int'(speed), 2);
      chk("t5_count2", int'(change_count), int'(exp_cnt));

      // Asynchronous reset during RESET state
      rx_dv = 1'b1;
      cfg_force_speed = 2'b01;
      expect_switch(2'b01);
      n = 0;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk);
         #1;
         if (mac_rst) begin
            n = i;
            break;
         end
      end
      chk("t6_switch_seen", int'(n != 0), 1);
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check_reset_vals("t6a");
      exp_cnt = 8'd0;
      cur_spd = 2'b10;
      cfg_force_en = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      measure_release("t6a_pulse");
      repeat (10) @(negedge clk);
      chk("t6a_speed", int'(speed), 2);
      chk("t6a_count", int'(change_count), 0);

      // Asynchronous reset mid-DRAIN
      cfg_force_en    = 1'b1;
      cfg_force_speed = 2'b00;
      tx_en = 1'b1;
      repeat (3) @(negedge clk);
      chk("t6b_hold", int'(mac_tx_hold), 1);
      chk("t6b_in_drain", int'(mac_rst), 0);
      #2;
      rst = 1'b1;
      #1;
      check_reset_vals("t6b");
      cfg_force_en = 1'b0;
      tx_en = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      measure_release("t6b_pulse");
      repeat (10) @(negedge clk);
      chk("t6b_speed", int'(speed), 2);
      chk("t6b_count", int'(change_count), 0);

      chk("sb_pending", sw_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
